// File: rtl/rtn_xbar_ch_sched.sv
// rtn_xbar_ch_sched: per-channel return-crossbar scheduler.
// Picks one of four bank response buffers round-robin and holds that grant
// until the channel accepts the beat, then pops the granted bank. Back-to-back
// grants keep the channel at one beat per cycle. proto_err flags a bank that
// drops its request while it is being held.
// Optional feature: define RTN_XBAR_SCHED_AGE_EN to add per-bank wait counters
// that restrict selection to banks that have waited AGE_LIMIT cycles or more.
module rtn_xbar_ch_sched #(
    parameter int NUM_BANK  = 4,
    parameter int AGE_W     = 4,
    parameter int AGE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sched_en,
    input  logic [NUM_BANK-1:0] bank_req_valid,
    input  logic [NUM_BANK-1:0] bank_req_more,
    input  logic                ch_rsp_ready,
    output logic                ch_rsp_valid,
    output logic [NUM_BANK-1:0] grant_1hot,
    output logic [1:0]          grant_bank_id,
    output logic [NUM_BANK-1:0] bank_pop,
    output logic                proto_err
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t              state_q, state_d;
    logic [NUM_BANK-1:0] gnt_q, gnt_d;
    logic [1:0]          ptr_q, ptr_d;
    logic                proto_err_q;

    logic                hold;
    logic                handshake;
    logic [1:0]          sel_ptr;
    logic [NUM_BANK-1:0] elig;
    logic [NUM_BANK-1:0] cand;
    logic [NUM_BANK-1:0] pick;

    // An AGE_LIMIT beyond the counter range could never be reached.
    if (AGE_LIMIT > (2 ** AGE_W) - 1) begin : g_age_limit_unreachable
    end

    // First set bit of req at or above ptr, wrapping 3 -> 0.
    function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [3:0] sel;
        logic [1:0] idx;
        sel = 4'b0000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) sel = 4'b0001 << idx;
        end
        return sel;
    endfunction

    // One-hot to binary; zero input encodes to 0.
    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (oh[k]) idx = 2'(k);
        end
        return idx;
    endfunction

    assign hold          = (state_q == HOLD);
    assign handshake     = hold & ch_rsp_ready;
    assign ch_rsp_valid  = hold;
    assign grant_1hot    = hold ? gnt_q : '0;
    assign grant_bank_id = onehot_idx(grant_1hot);
    assign bank_pop      = handshake ? gnt_q : '0;
    assign proto_err     = proto_err_q;

    // After a pop the search starts just past the bank that was served.
    assign sel_ptr = handshake ? onehot_idx(gnt_q) + 2'd1 : ptr_q;

    // A bank being popped stays eligible only if it holds another entry.
    assign elig = sched_en ? (bank_req_valid & ~(bank_pop & ~bank_req_more)) : '0;

`ifdef RTN_XBAR_SCHED_AGE_EN
    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_LIMIT);

    logic [NUM_BANK-1:0][AGE_W-1:0] age_q;
    logic [NUM_BANK-1:0]            aged;

    // Count cycles each bank waits with a request up; saturate at all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_q <= '0;
        end else begin
            for (int i = 0; i < NUM_BANK; i++) begin
                if (!bank_req_valid[i] || bank_pop[i]) begin
                    age_q[i] <= '0;
                end else if (age_q[i] != '1) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end

    // Aged banks, if any, take over the candidate set.
    always_comb begin
        aged = '0;
        for (int i = 0; i < NUM_BANK; i++) begin
            aged[i] = elig[i] && (age_q[i] >= AGE_LIM);
        end
    end

    assign cand = (aged != '0) ? aged : elig;
`else
    assign cand = elig;
`endif

    assign pick = rr_pick(cand, sel_ptr);

    // Grant, pointer and state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic: load a grant from idle, chain grants on handshake.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (elig != '0) begin
                    gnt_d   = pick;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ch_rsp_ready) begin
                    ptr_d = sel_ptr;
                    if (elig != '0) begin
                        gnt_d = pick;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Sticky error when the held bank withdraws its request before its pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err_q <= 1'b0;
        end else if (hold && ((bank_req_valid & gnt_q) == '0)) begin
            proto_err_q <= 1'b1;
        end
    end

endmodule

// File: doc/rtn_xbar_ch_sched.md
# rtn_xbar_ch_sched

Per-upstream-channel scheduler for the return crossbar: it picks which of the four bank response buffers drives one upstream channel, holds that choice until the channel accepts the beat, and pulses a pop to the granted bank. One instance sits at each of the three channel outputs of the return crossbar, between the bank buffer read pointers and the channel response handshake. It arbitrates round-robin with back-to-back grants, an enable gate for draining, sticky protocol-error detection, and an optional starvation guard.

## Interface
- NUM_BANK, 4: number of bank requesters; fixed at 4 in this design.
- AGE_W, 4: width of the per-bank wait counters. Used only with the starvation guard.
- AGE_LIMIT, 8: wait count at which a bank is promoted to aged. Must be ≤ 2^AGE_W-1.

- clk  in  1  clock; everything sampled on the rising edge.
- rst  in  1  asynchronous active-high reset.
- sched_en  in  1  when 0, no new grant is issued; a held grant still completes.
- bank_req_valid  in  4  bit i high: bank i buffer head holds an entry for this channel.
- bank_req_more  in  4  bit i high: bank i holds ≥2 entries for this channel. Only meaningful when bank_req_valid[i] is high.
- ch_rsp_ready  in  1  channel accepts the beat.
- ch_rsp_valid  out  1  a beat is presented to the channel.
- grant_1hot  out  4  selected bank, one-hot; 0 when ch_rsp_valid is low. Drives the crossbar data/rob_id mux.
- grant_bank_id  out  2  binary form of grant_1hot; 0 when idle.
- bank_pop  out  4  one-cycle pulse that advances the granted bank's read pointer.
- proto_err  out  1  sticky; set when a granted bank drops bank_req_valid before the pop. Cleared only by rst.

## Operation
- The state machine has two states, IDLE and HOLD. grant register gnt_q is 4 bits; rr pointer ptr_q is 2 bits.
- Eligible set E = bank_req_valid, masked as follows:
  - In a pop cycle, the popped bank stays eligible only if its bank_req_more bit is high.
  - When sched_en=0, E = 0.
- Selection is round-robin: the first set bit of E searching from ptr_q upward, wrapping 3→0.
- IDLE:
  - If E≠0: load gnt_q with the selection and go to HOLD.
  - Otherwise stay in IDLE.
- HOLD: ch_rsp_valid=1, grant_1hot=gnt_q, and gnt_q stays stable until handshake.
  - When ch_rsp_ready=1: bank_pop = gnt_q (combinational), and ptr_q ← granted index + 1 (mod 4).
  - In the same cycle, select from E using the updated pointer. If E≠0, load the new gnt_q and stay in HOLD (back-to-back). Otherwise go to IDLE.
- Protocol check: in HOLD, if bank_req_valid & gnt_q == 0, set proto_err. The grant is still held, so the datapath sees stale data; the bank must not do this.
- Simultaneous requests from all four banks are served in order ptr_q, ptr_q+1, … .
- A single bank with more=1 streams at 1 beat/cycle. With more=0, its last entry pops and the scheduler goes idle or moves to another bank.

## Timing
- Reset values: state=IDLE, gnt_q=0, ptr_q=0, ch_rsp_valid=0, grant_1hot=0, grant_bank_id=0, bank_pop=0, proto_err=0, age counters=0.
- Latency from request to valid: 1 cycle (bank_req_valid at edge N gives ch_rsp_valid high after edge N+1).
- Throughput: 1 beat/cycle while any bank stays eligible and ch_rsp_ready=1.
- rst asserted mid-HOLD: outputs clear immediately (asynchronously) and no pop is issued.
- When sched_en falls during HOLD, the current beat completes and the scheduler then goes to IDLE.

## Configuration
- RTN_XBAR_SCHED_AGE_EN defined: per-bank counters age[i] (AGE_W bits).
  - age[i] increments each cycle bank_req_valid[i]=1 and bank i is not popped; it saturates at all ones.
  - age[i] clears on pop of bank i or when bank_req_valid[i]=0.
  - If any eligible bank has age ≥ AGE_LIMIT, selection is restricted to those aged banks, with round-robin from ptr_q among them.
- Not defined: pure round-robin; the counters are not instantiated.

## Test plan
- Reset, then bank_req_valid=4'b0100, more=0, ready=1 → ch_rsp_valid at cycle+1, grant_bank_id=2, bank_pop=4'b0100 for one cycle, then idle; ptr_q=3.
- All 4 valid with more=1, ready=1 from reset → grants 0,1,2,3,0 on consecutive cycles, no bubbles.
- Grant on bank 1 with ready=0 for 5 cycles → grant_1hot=4'b0010 stable, bank_pop=0 throughout; ready=1 → single pop.
- Drop bank_req_valid[1] while bank 1 is held with ready=0 → proto_err=1 next cycle and it stays 1 until rst.
- sched_en=0 during HOLD on bank 3 → beat pops on ready, then IDLE with ch_rsp_valid=0 despite pending requests. Assert rst mid-HOLD → all outputs 0 immediately.
- AGE_EN, AGE_LIMIT=8: banks 0 and 1 stream (more=1) while bank 3 waits → bank 3 is granted no later than its 9th waiting cycle.
